// File: rtl/ram_reader.sv
// Streams a block of RAM port-B words, in address order, onto a valid/ready interface.
// Reads are credit-limited so the 3-entry output FIFO can never overflow under backpressure.
module ram_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] doutb,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_addr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   ONE_L = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   addrb_q, addrb_d;
  logic [ADDR_W-1:0]   infl_addr_q, infl_addr_d;
  logic [ADDR_W:0]     issue_rem_q, issue_rem_d;
  logic [ADDR_W:0]     deliver_rem_q, deliver_rem_d;
  logic                inflight_q;
  logic [1:0]          rd_ptr_q, rd_ptr_d;
  logic [1:0]          wr_ptr_q, wr_ptr_d;
  logic [1:0]          count_q, count_d;
  logic [DATA_W-1:0]   fifo_data_q [3];
  logic [ADDR_W-1:0]   fifo_addr_q [3];

  logic issue;
  logic push;
  logic pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit check sees registered occupancy only, so m_ready never reaches addrb.
  assign issue = (state_q == S_RUN) && (issue_rem_q != '0) &&
                 (({1'b0, count_q} + {2'b00, inflight_q}) < 3'd3);
  assign push  = inflight_q;
  assign pop   = m_valid && m_ready;

  assign addrb   = issue ? addr_q : addrb_q;
  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign m_valid = (count_q != 2'd0);
  assign m_data  = fifo_data_q[rd_ptr_q];
  assign m_addr  = fifo_addr_q[rd_ptr_q];

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    addrb_d       = addrb_q;
    infl_addr_d   = infl_addr_q;
    issue_rem_d   = issue_rem_q;
    deliver_rem_d = deliver_rem_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q + {1'b0, push} - {1'b0, pop};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d       = S_RUN;
            addr_d        = base_addr;
            issue_rem_d   = len;
            deliver_rem_d = len;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (pop && (deliver_rem_q == ONE_L)) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Issue stage: address goes to port B now, data returns next cycle.
    if (issue) begin
      addrb_d     = addr_q;
      infl_addr_d = addr_q;
      addr_d      = addr_q + ONE_A;
      issue_rem_d = issue_rem_q - ONE_L;
    end

    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end

    if (pop) begin
      rd_ptr_d      = ptr_inc(rd_ptr_q);
      deliver_rem_d = deliver_rem_q - ONE_L;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      addrb_q       <= '0;
      infl_addr_q   <= '0;
      issue_rem_q   <= '0;
      deliver_rem_q <= '0;
      inflight_q    <= 1'b0;
      rd_ptr_q      <= 2'd0;
      wr_ptr_q      <= 2'd0;
      count_q       <= 2'd0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      addrb_q       <= addrb_d;
      infl_addr_q   <= infl_addr_d;
      issue_rem_q   <= issue_rem_d;
      deliver_rem_q <= deliver_rem_d;
      inflight_q    <= issue;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // Capture stage: the word read last cycle lands in the FIFO with its address.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        fifo_data_q[i] <= '0;
        fifo_addr_q[i] <= '0;
      end
    end else if (push) begin
      fifo_data_q[wr_ptr_q] <= doutb;
      fifo_addr_q[wr_ptr_q] <= infl_addr_q;
    end
  end

endmodule

// File: tb/tb_ram_reader.sv
// Directed bench for ram_reader with a synchronous-read RAM model holding mem[a] = a*3.
module tb_ram_reader;
  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic [AW-1:0] addrb;
  logic [DW-1:0] doutb;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [AW-1:0] m_addr;

  int total  = 0;
  int passed = 0;

  ram_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .addrb(addrb), .doutb(doutb),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_addr(m_addr)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return {{(DW-AW){1'b0}}, a} * 32'd3;
  endfunction

  always @(posedge clk) doutb <= mem_f(addrb);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]    pat;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    int            got;
    int            donecnt;
    logic [AW-1:0] wa [4];
    logic [DW-1:0] wd [4];

    // Reset held two cycles with a start request pending
    rst = 1'b1; start = 1'b1; base_addr = 8'h33; len = 9'd5; m_ready = 1'b1;
    tick();
    check("rst1_busy", busy, 0);
    check("rst1_mvalid", m_valid, 0);
    tick();
    check("rst2_busy", busy, 0);
    check("rst2_done", done, 0);
    check("rst2_mvalid", m_valid, 0);
    check("rst2_mdata", m_data, 0);
    check("rst2_maddr", m_addr, 0);
    check("rst2_addrb", addrb, 0);
    rst = 1'b0; start = 1'b0;
    tick();
    check("post_rst_busy", busy, 0);
    check("post_rst_mvalid", m_valid, 0);
    check("post_rst_addrb", addrb, 0);

    // Basic burst: 4 words from 0x10, consumer always ready
    base_addr = 8'h10; len = 9'd4; start = 1'b1;
    tick();
    start = 1'b0;
    check("basic_busy", busy, 1);
    check("basic_addrb", addrb, 8'h10);
    check("basic_mvalid_e0", m_valid, 0);
    tick();
    check("basic_mvalid_e1", m_valid, 0);
    tick();
    check("basic_v0", m_valid, 1);
    check("basic_d0", m_data, 32'h30);
    check("basic_a0", m_addr, 8'h10);
    tick();
    check("basic_d1", m_data, 32'h33);
    check("basic_a1", m_addr, 8'h11);
    tick();
    check("basic_d2", m_data, 32'h36);
    check("basic_a2", m_addr, 8'h12);
    tick();
    check("basic_d3", m_data, 32'h39);
    check("basic_a3", m_addr, 8'h13);
    check("basic_done_early", done, 0);
    check("basic_busy_last", busy, 1);
    tick();
    check("basic_done", done, 1);
    check("basic_busy_done", busy, 0);
    check("basic_mvalid_done", m_valid, 0);
    // Start during DONE must be ignored
    base_addr = 8'h00; len = 9'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("done_once", done, 0);
    check("start_in_done_busy", busy, 0);
    tick();
    check("start_in_done_busy2", busy, 0);
    check("start_in_done_mvalid", m_valid, 0);

    // Backpressure: 8 words from 0x20, ready pattern 1,0,0,1,0,1,1,0 repeating
    pat = 8'b0110_1001;
    prev_stall = 1'b0; prev_data = '0; got = 0; donecnt = 0;
    base_addr = 8'h20; len = 9'd8; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 80 && !done; c++) begin
      if (m_valid && prev_stall) check("bp_stable", m_data, prev_data);
      if (c == 4) begin
        base_addr = 8'h80; len = 9'd3; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      m_ready = pat[c % 8];
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
      if (m_valid && m_ready) begin
        check("bp_addr", m_addr, 8'(8'h20 + got));
        check("bp_data", m_data, mem_f(8'(8'h20 + got)));
        got++;
      end
      tick();
      if (done) donecnt++;
    end
    start = 1'b0; m_ready = 1'b1;
    check("bp_done_seen", donecnt, 1);
    check("bp_count", got, 8);
    tick();
    check("bp_done_clear", done, 0);
    check("bp_busy_after", busy, 0);
    check("bp_mvalid_after", m_valid, 0);

    // Address wrap: 0xFE..0x01
    wa[0] = 8'hFE; wa[1] = 8'hFF; wa[2] = 8'h00; wa[3] = 8'h01;
    wd[0] = 32'h2FA; wd[1] = 32'h2FD; wd[2] = 32'h0; wd[3] = 32'h3;
    base_addr = 8'hFE; len = 9'd4; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      check("wrap_valid", m_valid, 1);
      check("wrap_addr", m_addr, wa[i]);
      check("wrap_data", m_data, wd[i]);
      tick();
    end
    check("wrap_done", done, 1);
    tick();

    // Zero length
    base_addr = 8'h55; len = 9'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    check("zero_mvalid", m_valid, 0);
    tick();
    check("zero_done_clear", done, 0);
    check("zero_busy2", busy, 0);
    check("zero_mvalid2", m_valid, 0);

    // Reset after two handshakes, then a clean 2-word transfer from 0x40
    base_addr = 8'h50; len = 9'd16; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    tick();
    check("mid_addr_before_rst", m_addr, 8'h52);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_mvalid", m_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_mdata", m_data, 0);
    check("mid_rst_addrb", addrb, 0);
    base_addr = 8'h40; len = 9'd2; start = 1'b1;
    tick();
    start = 1'b0;
    check("after_rst_busy", busy, 1);
    tick();
    check("after_rst_mvalid_e1", m_valid, 0);
    tick();
    check("after_rst_d0", m_data, 32'hC0);
    check("after_rst_a0", m_addr, 8'h40);
    tick();
    check("after_rst_d1", m_data, 32'hC3);
    check("after_rst_a1", m_addr, 8'h41);
    tick();
    check("after_rst_done", done, 1);
    check("after_rst_mvalid_end", m_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
